// File: rtl/cdb_arb.sv
// Common-data-bus arbiter: one small result FIFO per functional unit, a
// round-robin grant among the non-empty FIFOs, and a registered broadcast
// of the granted head onto the CDB.
module cdb_arb #(
  parameter int NREQ   = 4,
  parameter int TAG_W  = 4,
  parameter int QDEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*TAG_W-1:0]     req_tag,
  input  logic [NREQ*32-1:0]        req_wdata,
  output logic [NREQ-1:0]           req_ready,
  output logic                      cdb_wr,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [31:0]               cdb_wdata,
  output logic [$clog2(NREQ)-1:0]   cdb_src,
  output logic                      err_tag0
);

  localparam int SRC_W = $clog2(NREQ);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Requester index base+off, wrapped into 0..NREQ-1.
  function automatic logic [SRC_W-1:0] rr_idx(input logic [SRC_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return SRC_W'(s);
  endfunction

  logic [NREQ-1:0]         nonempty;
  logic [NREQ-1:0]         tag0_hit;
  logic [NREQ*TAG_W-1:0]   head_tag_flat;
  logic [NREQ*32-1:0]      head_data_flat;

  logic                    grant_valid;
  logic [SRC_W-1:0]        grant_idx;
  logic [SRC_W-1:0]        prio_q, prio_d;

  logic                    cdb_wr_q;
  logic [TAG_W-1:0]        cdb_tag_q;
  logic [31:0]             cdb_wdata_q;
  logic [SRC_W-1:0]        cdb_src_q;
  logic                    err_tag0_q;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_fifo
      logic [TAG_W-1:0] tag_mem_q  [QDEPTH];
      logic [31:0]      data_mem_q [QDEPTH];
      logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
      logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
      logic [CNT_W-1:0] count_q, count_d;
      logic             offer_acc;
      logic             push;
      logic             pop;
      logic [TAG_W-1:0] in_tag;

      assign in_tag        = req_tag[gi*TAG_W +: TAG_W];
      // Ready depends only on the registered count so it never loops through the grant.
      assign req_ready[gi] = (count_q != CNT_W'(QDEPTH)) && !flush;
      assign offer_acc     = req_valid[gi] && req_ready[gi];
      // Tag 0 means "no destination": the offer is consumed but never stored.
      assign push          = offer_acc && (in_tag != '0);
      assign tag0_hit[gi]  = offer_acc && (in_tag == '0);
      assign pop           = grant_valid && (grant_idx == SRC_W'(gi));
      assign nonempty[gi]  = (count_q != '0);

      assign head_tag_flat[gi*TAG_W +: TAG_W] = tag_mem_q[rd_ptr_q];
      assign head_data_flat[gi*32 +: 32]      = data_mem_q[rd_ptr_q];

      // Pointer/count next state; pointers wrap naturally since QDEPTH is a power of two.
      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end else begin
          if (push) wr_ptr_d = wr_ptr_q + 1'b1;
          if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
          case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
          endcase
        end
      end

      // FIFO control registers.
      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
        end
      end

      // FIFO storage; contents are don't-care while count is zero, so no reset.
      always_ff @(posedge clk) begin
        if (push) begin
          tag_mem_q[wr_ptr_q]  <= in_tag;
          data_mem_q[wr_ptr_q] <= req_wdata[gi*32 +: 32];
        end
      end
    end
  endgenerate

  // Round-robin pick: scan from prio upwards; the lowest offset found wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (!flush) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (nonempty[rr_idx(prio_q, i)]) begin
          grant_valid = 1'b1;
          grant_idx   = rr_idx(prio_q, i);
        end
      end
    end
  end

  assign prio_d = grant_valid ? rr_idx(grant_idx, 1) : prio_q;

  // Priority pointer, registered broadcast and sticky tag-0 error.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q      <= '0;
      cdb_wr_q    <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_wdata_q <= '0;
      cdb_src_q   <= '0;
      err_tag0_q  <= 1'b0;
    end else begin
      prio_q   <= prio_d;
      cdb_wr_q <= grant_valid;
      if (grant_valid) begin
        cdb_tag_q   <= head_tag_flat[grant_idx*TAG_W +: TAG_W];
        cdb_wdata_q <= head_data_flat[grant_idx*32 +: 32];
        cdb_src_q   <= grant_idx;
      end
      if (|tag0_hit) err_tag0_q <= 1'b1;
    end
  end

  assign cdb_wr    = cdb_wr_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_wdata = cdb_wdata_q;
  assign cdb_src   = cdb_src_q;
  assign err_tag0  = err_tag0_q;

endmodule

// File: tb/tb_cdb_arb.sv
// Directed bench for cdb_arb with default parameters (4 requesters, 4-bit tags, depth 2).
module tb_cdb_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [3:0]  req_valid;
  logic [15:0] req_tag;
  logic [127:0] req_wdata;
  logic [3:0]  req_ready;
  logic        cdb_wr;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_wdata;
  logic [1:0]  cdb_src;
  logic        err_tag0;

  int total = 0;
  int bad   = 0;

  cdb_arb #(.NREQ(4), .TAG_W(4), .QDEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .cdb_wr    (cdb_wr),
    .cdb_tag   (cdb_tag),
    .cdb_wdata (cdb_wdata),
    .cdb_src   (cdb_src),
    .err_tag0  (err_tag0)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [3:0] tag, input logic [31:0] data);
    req_tag[k*4 +: 4]     = tag;
    req_wdata[k*32 +: 32] = data;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Check one broadcast cycle in full.
  task automatic chk_bc(input string name, input logic [1:0] src, input logic [3:0] tag,
                        input logic [31:0] data);
    chk({name, ".wr"},   64'(cdb_wr),    64'(1));
    chk({name, ".src"},  64'(cdb_src),   64'(src));
    chk({name, ".tag"},  64'(cdb_tag),   64'(tag));
    chk({name, ".data"}, 64'(cdb_wdata), 64'(data));
    $display("bcast %s src=%0d tag=%0d data=%08h", name, cdb_src, cdb_tag, cdb_wdata);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = '0; req_tag = '0; req_wdata = '0;
    tick(); tick();
    chk("rst.wr",   64'(cdb_wr),    64'(0));
    chk("rst.tag",  64'(cdb_tag),   64'(0));
    chk("rst.data", 64'(cdb_wdata), 64'(0));
    chk("rst.src",  64'(cdb_src),   64'(0));
    chk("rst.err",  64'(err_tag0),  64'(0));
    rst = 1'b0;
    tick();
    chk("rst.ready", 64'(req_ready), 64'hF);

    // Single push: req 2, tag 5, 0xDEADBEEF.
    req_valid = 4'b0100; set_req(2, 4'd5, 32'hDEADBEEF);
    tick();
    req_valid = '0;
    chk("single.lat_wr", 64'(cdb_wr), 64'(0));
    tick();
    chk_bc("single", 2'd2, 4'd5, 32'hDEADBEEF);
    tick();
    chk("single.one_cycle", 64'(cdb_wr), 64'(0));
    chk("single.hold_tag",  64'(cdb_tag), 64'(5));
    chk("single.hold_data", 64'(cdb_wdata), 64'hDEADBEEF);
    chk("single.hold_src",  64'(cdb_src), 64'(2));

    // Reset again so prio returns to 0; it must also clear the held broadcast.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    chk("rst2.tag", 64'(cdb_tag), 64'(0));

    // Contention: all four push tags 1..4 on one edge.
    req_valid = 4'hF;
    for (int k = 0; k < 4; k++) set_req(k, 4'(k + 1), 32'h100 + 32'(k));
    tick();
    req_valid = '0;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk_bc("contend", 2'(j), 4'(j + 1), 32'h100 + 32'(j));
    end
    tick();
    chk("contend.idle", 64'(cdb_wr), 64'(0));

    // Backpressure on req 1 while req 0 takes the first grant (prio = 0).
    req_valid = 4'b0011; set_req(0, 4'd6, 32'hA0); set_req(1, 4'd7, 32'hB0);
    tick();
    chk("bp.ready1", 64'(req_ready), 64'hF);
    set_req(0, 4'd10, 32'hA1); set_req(1, 4'd8, 32'hB1);
    tick();
    chk("bp.full", 64'(req_ready), 64'b1101);
    chk_bc("bp.g0", 2'd0, 4'd6, 32'hA0);
    req_valid = 4'b0010; set_req(1, 4'd9, 32'hB2);
    tick();
    chk("bp.freed", 64'(req_ready), 64'hF);
    chk_bc("bp.g1", 2'd1, 4'd7, 32'hB0);
    tick();
    req_valid = '0;
    chk("bp.full2", 64'(req_ready), 64'b1101);
    chk_bc("bp.g2", 2'd0, 4'd10, 32'hA1);
    tick();
    chk_bc("bp.g3", 2'd1, 4'd8, 32'hB1);
    tick();
    chk_bc("bp.g4", 2'd1, 4'd9, 32'hB2);
    tick();
    chk("bp.idle", 64'(cdb_wr), 64'(0));

    // Fairness: 0 and 3 continuously valid; prio is 2 here.
    req_valid = 4'b1001; set_req(0, 4'd11, 32'hC0); set_req(3, 4'd12, 32'hC3);
    tick();
    chk("fair.first", 64'(cdb_wr), 64'(0));
    for (int j = 0; j < 6; j++) begin
      tick();
      if (j % 2 == 0) chk_bc("fair", 2'd3, 4'd12, 32'hC3);
      else            chk_bc("fair", 2'd0, 4'd11, 32'hC0);
    end
    req_valid = '0;
    for (int j = 0; j < 6; j++) tick();
    chk("fair.drained", 64'(cdb_wr), 64'(0));

    // Tag 0 offer from req 1.
    req_valid = 4'b0010; set_req(1, 4'd0, 32'h55);
    tick();
    req_valid = '0;
    chk("tag0.err",   64'(err_tag0),  64'(1));
    chk("tag0.ready", 64'(req_ready), 64'hF);
    tick();
    chk("tag0.nowr1", 64'(cdb_wr), 64'(0));
    tick();
    chk("tag0.nowr2", 64'(cdb_wr), 64'(0));
    chk("tag0.sticky", 64'(err_tag0), 64'(1));

    // Flush with three results queued.
    req_valid = 4'b0111;
    set_req(0, 4'd13, 32'hD0); set_req(1, 4'd14, 32'hD1); set_req(2, 4'd15, 32'hD2);
    tick();
    req_valid = '0; flush = 1'b1;
    #1;
    chk("flush.ready_low", 64'(req_ready), 64'h0);
    tick();
    chk("flush.nowr", 64'(cdb_wr), 64'(0));
    flush = 1'b0;
    #1;
    chk("flush.ready", 64'(req_ready), 64'hF);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("flush.silent", 64'(cdb_wr), 64'(0));
    end
    chk("flush.err_kept", 64'(err_tag0), 64'(1));

    // Reset mid-operation discards queued results and clears err_tag0.
    req_valid = 4'b1001; set_req(0, 4'd3, 32'hE0); set_req(3, 4'd4, 32'hE3);
    tick();
    req_valid = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid.wr",  64'(cdb_wr),   64'(0));
    chk("rstmid.err", 64'(err_tag0), 64'(0));
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("rstmid.silent", 64'(cdb_wr), 64'(0));
    end
    chk("rstmid.ready", 64'(req_ready), 64'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
